// File: rtl/window_3x3_line_buffer_pkg.sv
// window_3x3_line_buffer_pkg: pixel width, packed window field offsets shared with
// the downstream filter stages, and the window FSM states.
package window_3x3_line_buffer_pkg;

  localparam int PIX_W      = 12;
  localparam int WIN_W      = 9 * PIX_W;

  localparam int OFS_CENTER = 96;
  localparam int OFS_LEFT   = 84;
  localparam int OFS_RIGHT  = 72;
  localparam int OFS_UP     = 60;
  localparam int OFS_DOWN   = 48;
  localparam int OFS_UL     = 36;
  localparam int OFS_UR     = 24;
  localparam int OFS_DL     = 12;
  localparam int OFS_DR     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic [PIX_W-1:0] pix_mask(input logic [PIX_W-1:0] pix, input logic kill);
    return kill ? '0 : pix;
  endfunction

endpackage

// File: rtl/window_3x3_line_buffer_line_buffer.sv
// line_buffer: one image line of delay; the word at i_addr is read out in the same
// cycle it is overwritten, so the output is the pixel written DEPTH accepts earlier.
module line_buffer
  import window_3x3_line_buffer_pkg::*;
#(
  parameter int DEPTH = 160,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rdata
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/window_3x3_line_buffer.sv
// window_3x3_line_buffer: raster RGB444 stream in, packed 3x3 window out per centre.
// WINDOW_ZERO_PAD_EN: zero-padded window for every pixel plus a tail flush; otherwise interior only.
module window_3x3_line_buffer
  import window_3x3_line_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIX_W-1:0]              pix_in,
  input  logic                          pix_valid,
  input  logic                          sof,
  output logic                          pix_ready,
  output logic [WIN_W-1:0]              window_out,
  output logic                          window_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] center_y,
  output logic                          frame_done
);

  localparam int XW  = $clog2(IMG_WIDTH);
  localparam int YW  = $clog2(IMG_HEIGHT + 2);
  localparam int CYW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_t           r_state, w_state_nxt;
  logic [XW-1:0]    r_x, w_x, w_cx, r_cx;
  logic [YW-1:0]    r_y, w_y, w_cy;
  logic [CYW-1:0]   r_cy;
  logic             w_adv, w_restart;
  logic [PIX_W-1:0] w_pix, w_row1, w_row2;
  logic [PIX_W-1:0] r_top1, r_top2, r_mid1, r_mid2, r_bot1, r_bot2;
  logic             w_c_ok, w_at_l, w_at_r, w_at_t, w_at_b, w_emit, w_final;
  logic             w_ml, w_mr, w_mt, w_mb;
  logic [WIN_W-1:0] w_win, r_win;
  logic             r_win_valid, r_final, r_frame_done;

  // state | meaning
  // IDLE  | ready, waits for an accepted pixel with sof (taken as index 0)
  // RUN   | ready, each accept is the next raster index
  // FLUSH | not ready, injects IMG_WIDTH+1 zero pixels to close the last row
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_restart   = 1'b0;
    pix_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid && sof) begin
          w_adv       = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          w_adv     = 1'b1;
          w_restart = sof;
          if (!sof && r_x == X_LAST && r_y == Y_LAST)
`ifdef WINDOW_ZERO_PAD_EN
            w_state_nxt = FLUSH;
`else
            w_state_nxt = IDLE;
`endif
        end
      end
`ifdef WINDOW_ZERO_PAD_EN
      FLUSH: begin
        w_adv = 1'b1;
        if (r_x == '0 && r_y == YW'(IMG_HEIGHT + 1)) w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

`ifdef WINDOW_ZERO_PAD_EN
  assign w_pix = (r_state == FLUSH) ? '0 : pix_in;
`else
  assign w_pix = pix_in;
`endif

  assign w_x = w_restart ? '0 : r_x;
  assign w_y = w_restart ? '0 : r_y;

  line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb_row1 (
    .clk(clk), .i_we(w_adv), .i_addr(w_x), .i_wdata(w_pix), .o_rdata(w_row1)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb_row2 (
    .clk(clk), .i_we(w_adv), .i_addr(w_x), .i_wdata(w_row1), .o_rdata(w_row2)
  );

  // Centre trails the stream by IMG_WIDTH+1; at column 0 it is the previous row's last pixel.
  always_comb begin
    if (w_x == '0) begin
      w_cx = X_LAST;
      w_cy = w_y - YW'(2);
    end else begin
      w_cx = w_x - XW'(1);
      w_cy = w_y - YW'(1);
    end
  end

  assign w_c_ok = (w_y >= YW'(2)) || (w_y == YW'(1) && w_x != '0);
  assign w_at_l = (w_cx == '0);
  assign w_at_r = (w_cx == X_LAST);
  assign w_at_t = (w_cy == '0);
  assign w_at_b = (w_cy == Y_LAST);

`ifdef WINDOW_ZERO_PAD_EN
  assign w_emit  = w_adv && w_c_ok;
  assign w_final = w_at_r && w_at_b;
  assign w_ml = w_at_l;
  assign w_mr = w_at_r;
  assign w_mt = w_at_t;
  assign w_mb = w_at_b;
`else
  assign w_emit  = w_adv && w_c_ok && !w_at_l && !w_at_r && !w_at_t && !w_at_b;
  assign w_final = (w_cx == X_LAST - 1'b1) && (w_cy == Y_LAST - 1'b1);
  assign w_ml = 1'b0;
  assign w_mr = 1'b0;
  assign w_mt = 1'b0;
  assign w_mb = 1'b0;
`endif

  always_comb begin
    w_win = '0;
    w_win[OFS_CENTER +: PIX_W] = r_mid1;
    w_win[OFS_LEFT   +: PIX_W] = pix_mask(r_mid2, w_ml);
    w_win[OFS_RIGHT  +: PIX_W] = pix_mask(w_row1, w_mr);
    w_win[OFS_UP     +: PIX_W] = pix_mask(r_top1, w_mt);
    w_win[OFS_DOWN   +: PIX_W] = pix_mask(r_bot1, w_mb);
    w_win[OFS_UL     +: PIX_W] = pix_mask(r_top2, w_ml | w_mt);
    w_win[OFS_UR     +: PIX_W] = pix_mask(w_row2, w_mr | w_mt);
    w_win[OFS_DL     +: PIX_W] = pix_mask(r_bot2, w_ml | w_mb);
    w_win[OFS_DR     +: PIX_W] = pix_mask(w_pix,  w_mr | w_mb);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_top1       <= '0;
      r_top2       <= '0;
      r_mid1       <= '0;
      r_mid2       <= '0;
      r_bot1       <= '0;
      r_bot2       <= '0;
      r_win        <= '0;
      r_win_valid  <= 1'b0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_final      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= w_emit;
      r_final      <= w_emit && w_final;
      r_frame_done <= r_final;
      if (w_adv) begin
        if (w_x == X_LAST) begin
          r_x <= '0;
          r_y <= w_y + 1'b1;
        end else begin
          r_x <= w_x + 1'b1;
          r_y <= w_y;
        end
        r_top2 <= r_top1;
        r_top1 <= w_row2;
        r_mid2 <= r_mid1;
        r_mid1 <= w_row1;
        r_bot2 <= r_bot1;
        r_bot1 <= w_pix;
      end
      if (w_emit) begin
        r_win <= w_win;
        r_cx  <= w_cx;
        r_cy  <= CYW'(w_cy);
      end
    end
  end

  assign window_out   = r_win;
  assign window_valid = r_win_valid;
  assign center_x     = r_cx;
  assign center_y     = r_cy;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_window_3x3_line_buffer.sv
// tb_window_3x3_line_buffer: randomized stream driven into a 4x4 instance, every output
// compared each cycle against an index-based model of the windowing rules.
`timescale 1ns/1ps
module tb_window_3x3_line_buffer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
`ifdef WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int C_FINAL       = PAD ? N - 1 : (H - 2) * W + (W - 2);
  localparam int WIN_PER_FRAME = PAD ? N : (W - 2) * (H - 2);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [11:0]  pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         sof = 1'b0;
  logic         pix_ready;
  logic [107:0] window_out;
  logic         window_valid;
  logic [1:0]   center_x;
  logic [1:0]   center_y;
  logic         frame_done;

  window_3x3_line_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .pix_ready(pix_ready), .window_out(window_out), .window_valid(window_valid),
    .center_x(center_x), .center_y(center_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [107:0] got, input logic [107:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame image by raster index; mode 0 idle, 1 streaming, 2 flushing.
  logic [11:0]  img [N];
  int           m_mode = 0;
  int           m_next = 0;
  bit           exp_wv = 1'b0;
  bit           exp_fd = 1'b0;
  bit           last_final = 1'b0;
  logic [107:0] exp_win = '0;
  int           exp_cx = 0;
  int           exp_cy = 0;

  function automatic logic [11:0] nb(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
    return img[y * W + x];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_next = 0; exp_wv = 1'b0; exp_fd = 1'b0; last_final = 1'b0;
    end else begin
      int n, c, cx, cy;
      n = -1;
      exp_fd = last_final;
      case (m_mode)
        0: if (pix_valid && sof) begin n = 0; m_mode = 1; end
        1: if (pix_valid) begin
             n = sof ? 0 : m_next;
             if (!sof && n == N - 1) m_mode = PAD ? 2 : 0;
           end
        default: begin
          n = m_next;
          if (n == N + W) m_mode = 0;
        end
      endcase
      if (n >= 0) begin
        m_next = n + 1;
        if (n < N) img[n] = pix_in;
      end
      c  = n - W - 1;
      cx = (c >= 0) ? c % W : 0;
      cy = (c >= 0) ? c / W : 0;
      exp_wv = (n >= 0) && (c >= 0) && (c < N) &&
               (PAD || (cx >= 1 && cx <= W - 2 && cy >= 1 && cy <= H - 2));
      last_final = exp_wv && (c == C_FINAL);
      if (exp_wv) begin
        exp_cx  = cx;
        exp_cy  = cy;
        exp_win = {nb(cx, cy), nb(cx - 1, cy), nb(cx + 1, cy), nb(cx, cy - 1), nb(cx, cy + 1),
                   nb(cx - 1, cy - 1), nb(cx + 1, cy - 1), nb(cx - 1, cy + 1), nb(cx + 1, cy + 1)};
      end
    end
  end

  int win_cnt = 0;
  int fd_cnt  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      check_eq("window_valid", window_valid, exp_wv);
      check_eq("frame_done", frame_done, exp_fd);
      check_eq("pix_ready", pix_ready, m_mode != 2);
      if (window_valid && exp_wv) begin
        check_eq("window_out", window_out, exp_win);
        check_eq("center_x", center_x, exp_cx);
        check_eq("center_y", center_y, exp_cy);
      end
      if (window_valid) win_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic drive_pix(input logic [11:0] v, input bit s);
    pix_in = v; sof = s; pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0; pix_in = 12'h000;
  endtask

  task automatic gap(input int pct);
    for (int k = 0; k < 8 && $urandom_range(99) < pct; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_frame(input int n_pix, input bit rnd, input int pct);
    for (int i = 0; i < n_pix; i++) begin
      gap(pct);
      drive_pix(rnd ? 12'($urandom) : 12'(i), i == 0);
    end
  endtask

  task automatic drain();
    repeat (W + 4) @(posedge clk);
    #1;
  endtask

  task automatic frame_totals(input string tag, input int wins, input int fds);
    check_eq({tag, "_windows"}, win_cnt, wins);
    check_eq({tag, "_frame_done"}, fd_cnt, fds);
    win_cnt = 0;
    fd_cnt  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_window_valid"}, window_valid, 1'b0);
    check_eq({tag, "_frame_done"}, frame_done, 1'b0);
    check_eq({tag, "_window_out"}, window_out, '0);
    check_eq({tag, "_center_x"}, center_x, 2'd0);
    check_eq({tag, "_center_y"}, center_y, 2'd0);
    check_eq({tag, "_pix_ready"}, pix_ready, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) drive_pix(12'(i + 1), 1'b0);
    drain();
    frame_totals("idle_no_sof", 0, 0);

    drive_frame(N, 1'b0, 0);
    drain();
    frame_totals("contig", WIN_PER_FRAME, 1);

    drive_frame(N, 1'b0, 40);
    drain();
    frame_totals("gaps", WIN_PER_FRAME, 1);

    for (int f = 0; f < 3; f++) begin
      drive_frame(N, 1'b1, 25);
      drain();
      frame_totals("rand", WIN_PER_FRAME, 1);
    end

    drive_frame(7, 1'b0, 0);
    drive_frame(N, 1'b0, 0);
    drain();
    frame_totals("abort", WIN_PER_FRAME + (PAD ? 2 : 0), 1);

`ifdef WINDOW_ZERO_PAD_EN
    drive_frame(N, 1'b1, 0);
    repeat (2) @(posedge clk);
    #2;
`else
    drive_frame(11, 1'b1, 0);
    #2;
`endif
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset   = 1'b0;
    win_cnt = 0;
    fd_cnt  = 0;

    drive_frame(N, 1'b0, 0);
    drain();
    frame_totals("post_reset", WIN_PER_FRAME, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
